// File: rtl/ltc_monitor.sv
// Passive safety checker and statistics block for the traffic-light controller outputs.
// Define LTC_MON_CROSS_SEQ_EN to add sequence/yellow-timing checks on the cross road too.
module ltc_monitor #(
  parameter int unsigned TICK_DIV = 1000,
  parameter int unsigned YMIN     = 2,
  parameter int unsigned YMAX     = 5,
  parameter int unsigned PED_MAX  = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Jr,
  input  logic        Jy,
  input  logic        Jg,
  input  logic        Cr,
  input  logic        Cy,
  input  logic        Cg,
  input  logic        Pr,
  input  logic        Pg,
  input  logic        N,
  output logic        err,
  output logic [2:0]  err_code,
  output logic [15:0] cycles,
  output logic [7:0]  ped_wait
);

  localparam int unsigned PRE_W = 16;
  localparam int unsigned TMR_W = 8;

  typedef enum logic [1:0] {ST_UNK, ST_G, ST_Y, ST_R} road_e;

  typedef struct packed {
    logic n;
    logic pg;
    logic pr;
    logic cg;
    logic cy;
    logic cr;
    logic jg;
    logic jy;
    logic jr;
  } smp_t;

  function automatic logic onehot3(logic r, logic y, logic g);
    onehot3 = (r & ~y & ~g) | (~r & y & ~g) | (~r & ~y & g);
  endfunction

  function automatic road_e decode(logic y, logic g);
    decode = g ? ST_G : (y ? ST_Y : ST_R);
  endfunction

  function automatic logic bad_move(road_e cur, road_e nxt);
    bad_move = (cur != ST_UNK) && (nxt != cur) &&
               !((cur == ST_G && nxt == ST_Y) ||
                 (cur == ST_Y && nxt == ST_R) ||
                 (cur == ST_R && nxt == ST_G));
  endfunction

  // Yellow timer restarts on entry to Y and counts ticks while Y is held.
  function automatic logic [TMR_W-1:0] ytmr_next(road_e cur, road_e nxt, logic adv,
                                                 logic [TMR_W-1:0] tmr, logic tick);
    ytmr_next = tmr;
    if (adv && nxt == ST_Y) begin
      if (cur != ST_Y)                        ytmr_next = '0;
      else if (tick && tmr != {TMR_W{1'b1}})  ytmr_next = tmr + TMR_W'(1);
    end
  endfunction

  smp_t              smp_q, smp_d;
  logic              vld_q, vld_d;
  logic [PRE_W-1:0]  pre_q, pre_d;
  road_e             jst_q, jst_d;
  logic [TMR_W-1:0]  jyt_q, jyt_d;
  logic              n_prev_q, n_prev_d;
  logic              pg_prev_q, pg_prev_d;
  logic              pend_q, pend_d;
  logic [7:0]        pw_q, pw_d;
  logic              err_q, err_d;
  logic [2:0]        err_code_q, err_code_d;
  logic [15:0]       cycles_q, cycles_d;
  logic [7:0]        ped_wait_q, ped_wait_d;
`ifdef LTC_MON_CROSS_SEQ_EN
  road_e             cst_q, cst_d;
  logic [TMR_W-1:0]  cyt_q, cyt_d;
  road_e             c_nxt;
`endif

  logic       tick_c, adv, c1, c2, c3, c4, c5, c6, c7;
  road_e      j_nxt;
  logic [2:0] code;

  assign tick_c = (pre_q == PRE_W'(TICK_DIV - 1));

  always_comb begin
    pre_d      = tick_c ? '0 : pre_q + PRE_W'(1);
    smp_d      = '{n: N, pg: Pg, pr: Pr, cg: Cg, cy: Cy, cr: Cr, jg: Jg, jy: Jy, jr: Jr};
    vld_d      = 1'b1;
    n_prev_d   = smp_q.n;
    pg_prev_d  = smp_q.pg;
    pend_d     = pend_q;
    pw_d       = pw_q;
    ped_wait_d = ped_wait_q;
    cycles_d   = cycles_q;
    err_d      = err_q;
    err_code_d = err_code_q;
    c7         = 1'b0;
    code       = 3'd0;

    // Static light checks on the registered sample
    c1 = vld_q && !(onehot3(smp_q.jr, smp_q.jy, smp_q.jg) &&
                    onehot3(smp_q.cr, smp_q.cy, smp_q.cg) && (smp_q.pr ^ smp_q.pg));
    c2 = vld_q && (smp_q.jg | smp_q.jy) && (smp_q.cg | smp_q.cy);
    c3 = vld_q && smp_q.pg && (smp_q.jg | smp_q.jy | smp_q.cg | smp_q.cy);
    adv = vld_q && !c1;

    j_nxt = decode(smp_q.jy, smp_q.jg);
    jst_d = adv ? j_nxt : jst_q;
    jyt_d = ytmr_next(jst_q, j_nxt, adv, jyt_q, tick_c);
    c4    = adv && bad_move(jst_q, j_nxt);
    c5    = adv && jst_q == ST_Y && j_nxt != ST_Y && 32'(jyt_q) < YMIN;
    c6    = jst_q == ST_Y && 32'(jyt_q) > YMAX;
    if (adv && jst_q == ST_R && j_nxt == ST_G && cycles_q != 16'hFFFF)
      cycles_d = cycles_q + 16'd1;

`ifdef LTC_MON_CROSS_SEQ_EN
    c_nxt = decode(smp_q.cy, smp_q.cg);
    cst_d = adv ? c_nxt : cst_q;
    cyt_d = ytmr_next(cst_q, c_nxt, adv, cyt_q, tick_c);
    c4    = c4 | (adv && bad_move(cst_q, c_nxt));
    c5    = c5 | (adv && cst_q == ST_Y && c_nxt != ST_Y && 32'(cyt_q) < YMIN);
    c6    = c6 | (cst_q == ST_Y && 32'(cyt_q) > YMAX);
`endif

    // Pedestrian request tracking: service, timeout, count, new request
    if (pend_q && smp_q.pg && !pg_prev_q) begin
      ped_wait_d = pw_q;
      pend_d     = 1'b0;
    end else if (pend_q && 32'(pw_q) > PED_MAX) begin
      c7     = 1'b1;
      pend_d = 1'b0;
    end else if (pend_q) begin
      if (tick_c && pw_q != 8'hFF) pw_d = pw_q + 8'd1;
    end else if (smp_q.n && !n_prev_q) begin
      pend_d = 1'b1;
      pw_d   = '0;
    end

    if      (c1) code = 3'd1;
    else if (c2) code = 3'd2;
    else if (c3) code = 3'd3;
    else if (c4) code = 3'd4;
    else if (c5) code = 3'd5;
    else if (c6) code = 3'd6;
    else if (c7) code = 3'd7;

    if (!err_q && code != 3'd0) begin
      err_d      = 1'b1;
      err_code_d = code;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      smp_q      <= '0;
      vld_q      <= 1'b0;
      pre_q      <= '0;
      jst_q      <= ST_UNK;
      jyt_q      <= '0;
      n_prev_q   <= 1'b0;
      pg_prev_q  <= 1'b0;
      pend_q     <= 1'b0;
      pw_q       <= '0;
      err_q      <= 1'b0;
      err_code_q <= '0;
      cycles_q   <= '0;
      ped_wait_q <= '0;
`ifdef LTC_MON_CROSS_SEQ_EN
      cst_q      <= ST_UNK;
      cyt_q      <= '0;
`endif
    end else begin
      smp_q      <= smp_d;
      vld_q      <= vld_d;
      pre_q      <= pre_d;
      jst_q      <= jst_d;
      jyt_q      <= jyt_d;
      n_prev_q   <= n_prev_d;
      pg_prev_q  <= pg_prev_d;
      pend_q     <= pend_d;
      pw_q       <= pw_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      cycles_q   <= cycles_d;
      ped_wait_q <= ped_wait_d;
`ifdef LTC_MON_CROSS_SEQ_EN
      cst_q      <= cst_d;
      cyt_q      <= cyt_d;
`endif
    end
  end

  assign err      = err_q;
  assign err_code = err_code_q;
  assign cycles   = cycles_q;
  assign ped_wait = ped_wait_q;

endmodule

// File: tb/tb_ltc_monitor.sv
// Directed self-checking bench for ltc_monitor (TICK_DIV=4); a second instance uses PED_MAX=8.
module tb_ltc_monitor;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;
  localparam logic [1:0] P_RED = 2'b10;
  localparam logic [1:0] P_GRN = 2'b01;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] j_l = GRN;
  logic [2:0] c_l = RED;
  logic [1:0] p_l = P_RED;
  logic       n_req = 1'b0;

  logic        err, err8;
  logic [2:0]  err_code, err_code8;
  logic [15:0] cycles, cycles8;
  logic [7:0]  ped_wait, ped_wait8;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ltc_monitor #(.TICK_DIV(4), .YMIN(2), .YMAX(5), .PED_MAX(60)) u_dut (
    .clk(clk), .rst(rst_n),
    .Jr(j_l[2]), .Jy(j_l[1]), .Jg(j_l[0]),
    .Cr(c_l[2]), .Cy(c_l[1]), .Cg(c_l[0]),
    .Pr(p_l[1]), .Pg(p_l[0]), .N(n_req),
    .err(err), .err_code(err_code), .cycles(cycles), .ped_wait(ped_wait)
  );

  ltc_monitor #(.TICK_DIV(4), .YMIN(2), .YMAX(5), .PED_MAX(8)) u_dut8 (
    .clk(clk), .rst(rst_n),
    .Jr(j_l[2]), .Jy(j_l[1]), .Jg(j_l[0]),
    .Cr(c_l[2]), .Cy(c_l[1]), .Cg(c_l[0]),
    .Pr(p_l[1]), .Pg(p_l[0]), .N(n_req),
    .err(err8), .err_code(err_code8), .cycles(cycles8), .ped_wait(ped_wait8)
  );

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input logic [2:0] j, input logic [2:0] c);
    @(negedge clk);
    j_l = j; c_l = c; p_l = P_RED; n_req = 1'b0;
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    do_reset(GRN, RED);
    total++; if (err !== 1'b0)       begin bad++; $display("FAIL reset_err got=%0d want=0", err); end
    total++; if (err_code !== 3'd0)  begin bad++; $display("FAIL reset_code got=%0d want=0", err_code); end
    total++; if (cycles !== 16'd0)   begin bad++; $display("FAIL reset_cycles got=%0d want=0", cycles); end
    total++; if (ped_wait !== 8'd0)  begin bad++; $display("FAIL reset_pedwait got=%0d want=0", ped_wait); end
  endtask

  task automatic test_normal_cycle;
    do_reset(GRN, RED);
    cyc(12);
    j_l = YEL; cyc(12);
    j_l = RED; c_l = GRN; cyc(12);
    c_l = YEL; cyc(12);
    total++; if (cycles !== 16'd0) begin bad++; $display("FAIL normal_cycles_pre got=%0d want=0", cycles); end
    j_l = GRN; c_l = RED; cyc(12);
    total++; if (err !== 1'b0)      begin bad++; $display("FAIL normal_err got=%0d want=0", err); end
    total++; if (err_code !== 3'd0) begin bad++; $display("FAIL normal_code got=%0d want=0", err_code); end
    total++; if (cycles !== 16'd1)  begin bad++; $display("FAIL normal_cycles got=%0d want=1", cycles); end
  endtask

  task automatic test_bad_seq;
    do_reset(GRN, RED);
    cyc(4);
    j_l = RED;
    cyc(1);
    total++; if (err !== 1'b0) begin bad++; $display("FAIL seq_early got=%0d want=0", err); end
    cyc(1);
    total++; if (err !== 1'b1 || err_code !== 3'd4)
      begin bad++; $display("FAIL seq_code got=%0d/%0d want=1/4", err, err_code); end
    j_l = GRN; c_l = GRN;
    cyc(4);
    total++; if (err_code !== 3'd4) begin bad++; $display("FAIL seq_sticky got=%0d want=4", err_code); end
    total++; if (cycles !== 16'd1)  begin bad++; $display("FAIL seq_cycles_run got=%0d want=1", cycles); end
  endtask

  task automatic test_yellow_short;
    do_reset(GRN, RED);
    cyc(8);
    j_l = YEL; cyc(4);
    j_l = RED; cyc(3);
    total++; if (err !== 1'b1 || err_code !== 3'd5)
      begin bad++; $display("FAIL yel_short got=%0d/%0d want=1/5", err, err_code); end
  endtask

  task automatic test_yellow_long;
    do_reset(GRN, RED);
    cyc(8);
    j_l = YEL; cyc(18);
    total++; if (err !== 1'b0) begin bad++; $display("FAIL yel_long_early got=%0d want=0", err); end
    cyc(10);
    total++; if (err !== 1'b1)      begin bad++; $display("FAIL yel_long_err got=%0d want=1", err); end
    total++; if (err_code !== 3'd6) begin bad++; $display("FAIL yel_long_code got=%0d want=6", err_code); end
  endtask

  task automatic test_conflict;
    do_reset(GRN, RED);
    cyc(3);
    c_l = GRN; cyc(2);
    total++; if (err !== 1'b1)      begin bad++; $display("FAIL conf_err got=%0d want=1", err); end
    total++; if (err_code !== 3'd2) begin bad++; $display("FAIL conf_code got=%0d want=2", err_code); end
    do_reset(GRN, RED);
    cyc(3);
    j_l = 3'b110; c_l = GRN; cyc(2);
    total++; if (err !== 1'b1)      begin bad++; $display("FAIL onehot_err got=%0d want=1", err); end
    total++; if (err_code !== 3'd1) begin bad++; $display("FAIL onehot_code got=%0d want=1", err_code); end
    do_reset(GRN, RED);
    cyc(3);
    p_l = P_GRN; cyc(2);
    total++; if (err_code !== 3'd3) begin bad++; $display("FAIL ped_conf_code got=%0d want=3", err_code); end
    do_reset(GRN, RED);
    cyc(3);
    p_l = 2'b00; cyc(2);
    total++; if (err_code !== 3'd1) begin bad++; $display("FAIL ped_dark_code got=%0d want=1", err_code); end
  endtask

  task automatic test_ped;
    do_reset(RED, RED);
    cyc(3);
    n_req = 1'b1; cyc(1);
    n_req = 1'b0; cyc(29);
    total++; if (err8 !== 1'b0) begin bad++; $display("FAIL ped8_early got=%0d want=0", err8); end
    cyc(10);
    total++; if (err8 !== 1'b1 || err_code8 !== 3'd7)
      begin bad++; $display("FAIL ped8_timeout got=%0d/%0d want=1/7", err8, err_code8); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL ped_no_timeout got=%0d want=0", err); end
    cyc(1);
    p_l = P_GRN; cyc(3);
    total++; if (ped_wait !== 8'd10) begin bad++; $display("FAIL ped_wait got=%0d want=10", ped_wait); end
    total++; if (err !== 1'b0)       begin bad++; $display("FAIL ped_err got=%0d want=0", err); end
    total++; if (ped_wait8 !== 8'd0) begin bad++; $display("FAIL ped8_wait got=%0d want=0", ped_wait8); end
  endtask

  task automatic test_async_reset;
    do_reset(GRN, RED);
    cyc(2);
    c_l = GRN; cyc(3);
    c_l = RED; cyc(4);
    j_l = YEL; cyc(4);
    total++; if (err !== 1'b1) begin bad++; $display("FAIL ar_pre_err got=%0d want=1", err); end
    #1 rst_n = 1'b0;
    #1;
    total++; if (err !== 1'b0)      begin bad++; $display("FAIL ar_err got=%0d want=0", err); end
    total++; if (err_code !== 3'd0) begin bad++; $display("FAIL ar_code got=%0d want=0", err_code); end
    total++; if (cycles !== 16'd0)  begin bad++; $display("FAIL ar_cycles got=%0d want=0", cycles); end
    total++; if (ped_wait !== 8'd0) begin bad++; $display("FAIL ar_pedwait got=%0d want=0", ped_wait); end
    cyc(2);
    rst_n = 1'b1;
    cyc(12);
    j_l = RED; cyc(4);
    total++; if (err !== 1'b0)      begin bad++; $display("FAIL ar_restart_err got=%0d want=0", err); end
    total++; if (err_code !== 3'd0) begin bad++; $display("FAIL ar_restart_code got=%0d want=0", err_code); end
  endtask

  initial begin
    test_reset();
    test_normal_cycle();
    test_bad_seq();
    test_yellow_short();
    test_yellow_long();
    test_conflict();
    test_ped();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
